// File: rtl/wait_arbiter_pkg.sv
// Shared types and constants for the wait arbiter: FSM state encoding,
// minimum wait length and default sizing.
package wait_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MIN_T     = 4;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/wait_arbiter_timer.sv
// Shared wait counter: latches the terminal count on clr, counts up to it
// and decodes the quarter-mark phase pattern.
module wait_timer
  import wait_arbiter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] T,
  output logic [CNT_W-1:0] cnt,
  output logic             phase,
  output logic             hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_t;
  logic [CNT_W-1:0] w_q1;
  logic [CNT_W-1:0] w_q2;
  logic [CNT_W-1:0] w_q3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_t   <= CNT_W'(MIN_T);
    end else if (clr) begin
      r_cnt <= '0;
      r_t   <= T;
    end else if (en && (r_cnt != r_t)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // q1 + q2 never exceeds 3/4 of T, so the sum fits in CNT_W bits
  assign w_q1  = r_t >> 2;
  assign w_q2  = r_t >> 1;
  assign w_q3  = w_q1 + w_q2;

  assign cnt   = r_cnt;
  assign hit   = (r_cnt == r_t);
  assign phase = ((r_cnt >= w_q1) && (r_cnt < w_q2)) ||
                 ((r_cnt >= w_q3) && (r_cnt < r_t));

endmodule

// File: rtl/wait_arbiter.sv
// Round-robin arbiter granting a single shared wait timer to N_REQ
// requesters; aborts when the granted request is withdrawn.
module wait_arbiter
  import wait_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] term,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             phase,
  output logic [N_REQ-1:0] done,
  output logic [CNT_W-1:0] cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_win;
  logic [IDX_W-1:0] w_win_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_clr;
  logic             w_en;
  logic             w_hit;
  logic             w_timer_phase;
  logic [CNT_W-1:0] w_term_clamped;
  logic [N_REQ-1:0] w_win_onehot;

  // Search starts one past the last served index so every holder gets a turn
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign w_win_onehot[gi] = (r_win == IDX_W'(gi));
  end

  assign w_term_clamped = (term < CNT_W'(MIN_T)) ? CNT_W'(MIN_T) : term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_next;
      r_win   <= w_win_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_win_next   = r_win;
    w_ptr_next   = r_ptr;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next = ST_GRANT;
          w_win_next   = w_pick;
        end
      end
      ST_GRANT: begin
        if (!req[r_win]) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = r_win;
        end else begin
          w_clr        = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[r_win]) begin
          w_state_next = ST_IDLE;
          w_ptr_next   = r_win;
        end else if (w_hit) begin
          w_state_next = ST_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_ptr_next   = r_win;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_en),
    .T     (w_term_clamped),
    .cnt   (cnt),
    .phase (w_timer_phase),
    .hit   (w_hit)
  );

  assign busy  = (r_state != ST_IDLE);
  assign gnt   = busy ? w_win_onehot : '0;
  assign done  = (r_state == ST_DONE) ? w_win_onehot : '0;
  assign phase = w_timer_phase && (r_state == ST_RUN);

endmodule
